// File: rtl/fpmult_pipe.sv
// Three-stage valid/ready floating-point multiplier: RNE rounding, input denormal flush, tag pass-through.
// Define FPMULT_FLAGS_EN to add the registered {invalid,overflow,underflow,inexact} flags output.
module fpmult_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   res,
    output logic [TAG_W-1:0]       out_tag
`ifdef FPMULT_FLAGS_EN
    ,
    output logic [3:0]             flags
`endif
);

    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned P_W  = 2 * (MAN_W + 1);
    localparam int unsigned E_W  = EXP_W + 2;
    localparam int unsigned BIAS = (2 ** (EXP_W - 1)) - 1;
    localparam int unsigned EMAX = (2 ** EXP_W) - 1;
    localparam logic [E_W-1:0] EMAX_E = E_W'(EMAX);

    // Whole pipe advances together; a stalled output freezes every stage.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign ea     = a[W-2 -: EXP_W];
    assign eb     = b[W-2 -: EXP_W];
    assign ma     = a[MAN_W-1:0];
    assign mb     = b[MAN_W-1:0];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1) && (ma == '0);
    assign b_inf  = (eb == '1) && (mb == '0);
    assign a_nan  = (ea == '1) && (ma != '0);
    assign b_nan  = (eb == '1) && (mb != '0);

    logic             s0_valid_q;
    logic             s0_sign_q, s0_nan_q, s0_inf_q, s0_zero_q;
    logic             s0_sign_d, s0_nan_d, s0_inf_d, s0_zero_d;
    logic [E_W-1:0]   s0_exp_q, s0_exp_d;
    logic [P_W-1:0]   s0_prod_q, s0_prod_d;
    logic [TAG_W-1:0] s0_tag_q;

    // S0: classify operands, sign, biased exponent sum, significand product
    always_comb begin
        s0_sign_d = a[W-1] ^ b[W-1];
        s0_nan_d  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
        s0_inf_d  = a_inf || b_inf;
        s0_zero_d = a_zero || b_zero;
        s0_exp_d  = E_W'(ea) + E_W'(eb) - E_W'(BIAS);
        s0_prod_d = P_W'({!a_zero, ma}) * P_W'({!b_zero, mb});
    end

    logic             s1_valid_q;
    logic             s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q;
    logic [E_W-1:0]   s1_exp_q, s1_exp_d;
    logic [MAN_W-1:0] s1_man_q, s1_man_d;
    logic [TAG_W-1:0] s1_tag_q;
    logic [P_W-1:0]   norm;
    logic             hi, g_bit, r_bit, s_bit, rnd_inc;
    logic [MAN_W+1:0] mant_r;

    // S1: normalise to 1.x, round to nearest even, renormalise on carry-out
    always_comb begin
        hi       = s0_prod_q[P_W-1];
        norm     = hi ? s0_prod_q : {s0_prod_q[P_W-2:0], 1'b0};
        g_bit    = norm[MAN_W];
        r_bit    = norm[MAN_W-1];
        s_bit    = |norm[MAN_W-2:0];
        rnd_inc  = g_bit && (r_bit || s_bit || norm[MAN_W+1]);
        mant_r   = {1'b0, norm[P_W-1 -: MAN_W+1]} + (MAN_W+2)'(rnd_inc);
        s1_man_d = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
        s1_exp_d = s0_exp_q + E_W'(hi) + E_W'(mant_r[MAN_W+1]);
    end

`ifdef FPMULT_FLAGS_EN
    logic s1_inexact_q;
    logic [3:0] flags_d;
`endif

    logic         exp_ovf, exp_unf;
    logic [W-1:0] res_d;

    assign exp_ovf = !s1_exp_q[E_W-1] && (s1_exp_q >= EMAX_E);
    assign exp_unf = s1_exp_q[E_W-1] || (s1_exp_q == '0);

    // S2: exception priority and final packing
    always_comb begin
        res_d = '0;
        if (s1_nan_q) begin
            res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (s1_inf_q || (!s1_zero_q && exp_ovf)) begin
            res_d = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s1_zero_q || exp_unf) begin
            res_d = {s1_sign_q, {(W-1){1'b0}}};
        end else begin
            res_d = {s1_sign_q, s1_exp_q[EXP_W-1:0], s1_man_q};
        end
    end

`ifdef FPMULT_FLAGS_EN
    always_comb begin
        flags_d = '0;
        if (s1_nan_q) begin
            flags_d = 4'b1000;
        end else if (s1_inf_q || s1_zero_q) begin
            flags_d = 4'b0000;
        end else if (exp_ovf) begin
            flags_d = 4'b0101;
        end else if (exp_unf) begin
            flags_d = 4'b0011;
        end else begin
            flags_d = {3'b000, s1_inexact_q};
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            s0_valid_q   <= 1'b0;
            s0_sign_q    <= 1'b0;
            s0_nan_q     <= 1'b0;
            s0_inf_q     <= 1'b0;
            s0_zero_q    <= 1'b0;
            s0_exp_q     <= '0;
            s0_prod_q    <= '0;
            s0_tag_q     <= '0;
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_nan_q     <= 1'b0;
            s1_inf_q     <= 1'b0;
            s1_zero_q    <= 1'b0;
            s1_exp_q     <= '0;
            s1_man_q     <= '0;
            s1_tag_q     <= '0;
            out_valid    <= 1'b0;
            res          <= '0;
            out_tag      <= '0;
`ifdef FPMULT_FLAGS_EN
            s1_inexact_q <= 1'b0;
            flags        <= '0;
`endif
        end else if (adv) begin
            s0_valid_q   <= in_valid;
            s0_sign_q    <= s0_sign_d;
            s0_nan_q     <= s0_nan_d;
            s0_inf_q     <= s0_inf_d;
            s0_zero_q    <= s0_zero_d;
            s0_exp_q     <= s0_exp_d;
            s0_prod_q    <= s0_prod_d;
            s0_tag_q     <= in_tag;
            s1_valid_q   <= s0_valid_q;
            s1_sign_q    <= s0_sign_q;
            s1_nan_q     <= s0_nan_q;
            s1_inf_q     <= s0_inf_q;
            s1_zero_q    <= s0_zero_q;
            s1_exp_q     <= s1_exp_d;
            s1_man_q     <= s1_man_d;
            s1_tag_q     <= s0_tag_q;
            out_valid    <= s1_valid_q;
            res          <= res_d;
            out_tag      <= s1_tag_q;
`ifdef FPMULT_FLAGS_EN
            s1_inexact_q <= g_bit || r_bit || s_bit;
            flags        <= flags_d;
`endif
        end
    end

endmodule
